// File: rtl/tone_i2s_tx.sv
// Stereo sample FIFO feeding an I2S (or, with I2S_LJ_FORMAT_EN, left-justified) serialiser.
// Bit clock is derived from clk; an empty FIFO at frame start sends silence and pulses underrun.
module tone_i2s_tx #(
   parameter int unsigned WIDTH      = 24,
   parameter int unsigned BCLK_DIV   = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [WIDTH-1:0]              s_left,
   input  logic [WIDTH-1:0]              s_right,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_sdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DW-1:0] DivMax    = DW'(BCLK_DIV - 1);
   localparam logic [LW-1:0] FullLevel = LW'(FIFO_DEPTH);

   typedef enum logic {StIdle, StRun} state_e;

   state_e               state_q;
   logic                 first_q;
   logic [5:0]           slot_q;
   logic [DW-1:0]        div_q;
   logic                 bclk_q, lrclk_q, sdata_q, underrun_q;
   logic [2*WIDTH-1:0]   frame_q;

   logic [2*WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_q, rd_q;
   logic [LW-1:0]        level_q;

   logic                 push, pop, fifo_empty;
   logic                 tick, fall, frame_start, load, stop;
   logic [5:0]           slot_nxt;
   logic [2*WIDTH-1:0]   frame_src;
   logic [WIDTH-1:0]     sample, shifted;
   logic                 sdata_nxt, lrclk_nxt;

   assign s_ready    = (level_q != FullLevel);
   assign fifo_empty = (level_q == '0);
   assign push       = s_valid && s_ready;

   assign tick        = (div_q == DivMax);
   assign fall        = (state_q == StRun) && tick && bclk_q;
   // The first falling edge after RUN entry opens slot 0 instead of advancing.
   assign slot_nxt    = first_q ? 6'd0 : slot_q + 6'd1;
   assign frame_start = (slot_nxt == 6'd0);
   assign load        = fall && frame_start && enable;
   assign stop        = fall && frame_start && !enable;
   assign pop         = load && !fifo_empty;
   assign frame_src   = load ? (fifo_empty ? '0 : mem[rd_q]) : frame_q;

   always_comb begin
      sample = slot_nxt[5] ? frame_src[WIDTH-1:0] : frame_src[2*WIDTH-1:WIDTH];
`ifdef I2S_LJ_FORMAT_EN
      shifted   = sample << slot_nxt[4:0];
      sdata_nxt = shifted[WIDTH-1];
      lrclk_nxt = ~slot_nxt[5];
`else
      // One-bit delay: position 0 is blank, MSB lands on position 1.
      shifted   = sample << (slot_nxt[4:0] - 5'd1);
      sdata_nxt = (slot_nxt[4:0] != 5'd0) && shifted[WIDTH-1];
      lrclk_nxt = slot_nxt[5];
`endif
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= {s_left, s_right};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         first_q    <= 1'b1;
         slot_q     <= '0;
         div_q      <= '0;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
         frame_q    <= '0;
      end else begin
         underrun_q <= 1'b0;
         case (state_q)
            StIdle: begin
               first_q <= 1'b1;
               slot_q  <= '0;
               div_q   <= '0;
               bclk_q  <= 1'b0;
               lrclk_q <= 1'b0;
               sdata_q <= 1'b0;
               if (enable) state_q <= StRun;
            end
            StRun: begin
               if (tick) begin
                  div_q  <= '0;
                  bclk_q <= ~bclk_q;
               end else begin
                  div_q <= div_q + 1'b1;
               end
               if (stop) begin
                  state_q <= StIdle;
                  first_q <= 1'b1;
                  slot_q  <= '0;
                  lrclk_q <= 1'b0;
                  sdata_q <= 1'b0;
               end else if (fall) begin
                  first_q <= 1'b0;
                  slot_q  <= slot_nxt;
                  lrclk_q <= lrclk_nxt;
                  sdata_q <= sdata_nxt;
                  if (load) begin
                     frame_q    <= frame_src;
                     underrun_q <= fifo_empty;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign i2s_bclk   = bclk_q;
   assign i2s_lrclk  = lrclk_q;
   assign i2s_sdata  = sdata_q;
   assign underrun   = underrun_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_tone_i2s_tx.sv
// Directed bench for tone_i2s_tx: captures SDATA/LRCLK on BCLK rising edges and
// compares against hand-derived slot patterns (expectations follow I2S_LJ_FORMAT_EN).
module tb_tone_i2s_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        s_valid;
   logic        s_ready;
   logic [23:0] s_left, s_right;
   logic        i2s_bclk, i2s_lrclk, i2s_sdata;
   logic [2:0]  fifo_level;
   logic        underrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int und_cnt = 0;
   int und_last = 0;
   int und_prev = 0;

   tone_i2s_tx #(.WIDTH(24), .BCLK_DIV(2), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_left     (s_left),
      .s_right    (s_right),
      .i2s_bclk   (i2s_bclk),
      .i2s_lrclk  (i2s_lrclk),
      .i2s_sdata  (i2s_sdata),
      .fifo_level (fifo_level),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (underrun) begin
         und_cnt++;
         und_prev = und_last;
         und_last = cyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

`ifdef I2S_LJ_FORMAT_EN
   localparam logic [31:0] LR_L = 32'hFFFF_FFFF;
   localparam logic [31:0] LR_R = 32'h0000_0000;
`else
   localparam logic [31:0] LR_L = 32'h0000_0000;
   localparam logic [31:0] LR_R = 32'hFFFF_FFFF;
`endif

   logic [23:0] tl [6];
   logic [23:0] tr [6];
   logic [31:0] el [6];
   logic [31:0] er [6];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rise(input int budget, output bit found, output int n);
      logic prev;
      found = 1'b0;
      n = 0;
      prev = i2s_bclk;
      while (!found && n < budget) begin
         @(negedge clk);
         n++;
         if (!prev && i2s_bclk) found = 1'b1;
         prev = i2s_bclk;
      end
   endtask

   task automatic grab(input int cnt, output logic [63:0] d, output logic [63:0] lr,
                       output int last_n);
      bit found;
      int n;
      d = '0;
      lr = '0;
      last_n = 0;
      for (int i = 0; i < cnt; i++) begin
         wait_rise(64, found, n);
         if (!found) check("bclk_rise_timeout", 64'(found), 64'd1);
         d = {d[62:0], i2s_sdata};
         lr = {lr[62:0], i2s_lrclk};
         last_n = n;
      end
   endtask

   initial begin
      logic [63:0] d, lr;
      int n, w;
      bit found;

      tl[0] = 24'h800001; tr[0] = 24'h7FFFFF;
      tl[1] = 24'h123456; tr[1] = 24'hFEDCBA;
      tl[2] = 24'hC00000; tr[2] = 24'h000001;
      tl[3] = 24'h5A5A5A; tr[3] = 24'hA5A5A5;
      tl[4] = 24'h7FFFFF; tr[4] = 24'h800000;
      tl[5] = 24'h0F0F0F; tr[5] = 24'hF0F0F0;
`ifdef I2S_LJ_FORMAT_EN
      el[0] = 32'h8000_0100; er[0] = 32'h7FFF_FF00;
      el[1] = 32'h1234_5600; er[1] = 32'hFEDC_BA00;
      el[2] = 32'hC000_0000; er[2] = 32'h0000_0100;
`else
      el[0] = 32'h4000_0080; er[0] = 32'h3FFF_FF80;
      el[1] = 32'h091A_2B00; er[1] = 32'h7F6E_5D00;
      el[2] = 32'h6000_0000; er[2] = 32'h0000_0080;
`endif
      el[3] = '0; er[3] = '0; el[4] = '0; er[4] = '0; el[5] = '0; er[5] = '0;

      rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
      @(negedge clk);
      check("rst_bclk", 64'(i2s_bclk), 64'd0);
      check("rst_lrclk", 64'(i2s_lrclk), 64'd0);
      check("rst_sdata", 64'(i2s_sdata), 64'd0);
      check("rst_underrun", 64'(underrun), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_ready", 64'(s_ready), 64'd1);

      // One pair, then run the bus.
      @(negedge clk); rst = 1'b0;
      @(negedge clk); s_left = tl[0]; s_right = tr[0]; s_valid = 1'b1;
      @(negedge clk); s_valid = 1'b0;
      check("level_after_push", 64'(fifo_level), 64'd1);
      enable = 1'b1;
      wait_rise(64, found, n);
      check("pre_slot_rise", 64'(found), 64'd1);
      grab(32, d, lr, n);
      check("f0_left_data", d[31:0], 64'(el[0]));
      check("f0_left_lr", lr[31:0], 64'(LR_L));
      check("bclk_period", 64'(n), 64'd4);
      check("f0_level", 64'(fifo_level), 64'd0);
      grab(32, d, lr, n);
      check("f0_right_data", d[31:0], 64'(er[0]));
      check("f0_right_lr", lr[31:0], 64'(LR_R));
      check("f0_no_underrun", 64'(und_cnt), 64'd0);

      // Empty FIFO: silence, lrclk keeps toggling, one underrun per frame.
      grab(64, d, lr, n);
      check("f1_data_zero", d, 64'd0);
      check("f1_lr", lr, {LR_L, LR_R});
      check("f1_underrun", 64'(und_cnt), 64'd1);
      grab(1, d, lr, n);
      check("f2_underrun", 64'(und_cnt), 64'd2);
      check("frame_len", 64'(und_last - und_prev), 64'd256);

      // Drop enable early in frame 2: frame completes, then bus idles.
      enable = 1'b0;
      grab(63, d, lr, n);
      check("f2_data_zero", d[62:0], 64'd0);
      wait_rise(40, found, n);
      check("idle_no_rise", 64'(found), 64'd0);
      check("idle_bclk", 64'(i2s_bclk), 64'd0);
      check("idle_lrclk", 64'(i2s_lrclk), 64'd0);
      check("idle_sdata", 64'(i2s_sdata), 64'd0);
      check("idle_underrun_cnt", 64'(und_cnt), 64'd2);

      // Fill the FIFO while idle; the fifth pair must wait.
      for (int i = 1; i <= 4; i++) begin
         s_left = tl[i]; s_right = tr[i]; s_valid = 1'b1;
         check($sformatf("ready_push%0d", i), 64'(s_ready), 64'd1);
         @(negedge clk);
      end
      s_left = tl[5]; s_right = tr[5];
      check("full_level", 64'(fifo_level), 64'd4);
      check("full_ready", 64'(s_ready), 64'd0);
      repeat (3) @(negedge clk);
      check("full_held_level", 64'(fifo_level), 64'd4);

      // Run again; first load frees a slot for the held pair.
      enable = 1'b1;
      wait_rise(64, found, n);
      w = 0;
      while (!s_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("ready_after_pop", 64'(s_ready), 64'd1);
      @(negedge clk); s_valid = 1'b0;
      check("level_refill", 64'(fifo_level), 64'd4);
      grab(11, d, lr, n);
      check("p1_left_hi", d[10:0], 64'(el[1][31:21]));
      enable = 1'b0;
      grab(21, d, lr, n);
      check("p1_left_lo", d[20:0], 64'(el[1][20:0]));
      grab(32, d, lr, n);
      check("p1_right", d[31:0], 64'(er[1]));
      check("p1_right_lr", lr[31:0], 64'(LR_R));
      wait_rise(40, found, n);
      check("stop_no_rise", 64'(found), 64'd0);
      check("stop_level", 64'(fifo_level), 64'd4);
      check("stop_sdata", 64'(i2s_sdata), 64'd0);
      check("stop_underrun_cnt", 64'(und_cnt), 64'd2);

      // Reset in the right slot with three pairs buffered.
      enable = 1'b1;
      wait_rise(64, found, n);
      grab(32, d, lr, n);
      check("p2_left", d[31:0], 64'(el[2]));
      check("p2_left_lr", lr[31:0], 64'(LR_L));
      check("p2_level", 64'(fifo_level), 64'd3);
      grab(9, d, lr, n);
      check("p2_right_hi", d[8:0], 64'(er[2][31:23]));
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_bclk", 64'(i2s_bclk), 64'd0);
      check("mid_rst_lrclk", 64'(i2s_lrclk), 64'd0);
      check("mid_rst_sdata", 64'(i2s_sdata), 64'd0);
      check("mid_rst_underrun", 64'(underrun), 64'd0);
      check("mid_rst_level", 64'(fifo_level), 64'd0);
      check("mid_rst_ready", 64'(s_ready), 64'd1);
      enable = 1'b0;
      @(negedge clk); rst = 1'b0;
      repeat (10) @(negedge clk);
      check("post_rst_bclk", 64'(i2s_bclk), 64'd0);
      check("post_rst_underrun_cnt", 64'(und_cnt), 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tone_i2s_tx.md
Name: tone_i2s_tx

Overview:
- Downstream consumer of the sine/cosine tone generator.
- Accepts signed stereo sample pairs (typically sin on left, cos on right) through a valid/ready handshake and buffers them in a small FIFO.
- Serialises the samples onto a standard I2S bus (BCLK, LRCLK, SDATA) for the audio DAC/codec, using bit clocks derived from clk.
- Underrun is flagged; the line never stalls.

Parameters:
- WIDTH, 24, sample width in bits; must be ≤ 31.
- BCLK_DIV, 4, clk cycles per BCLK half-period; must be ≥ 1.
- FIFO_DEPTH, 4, stereo-pair FIFO entries; power of 2, ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run the I2S bus
- s_valid  in  1  sample pair valid
- s_ready  out  1  FIFO can accept a pair
- s_left  in  WIDTH  signed left sample
- s_right  in  WIDTH  signed right sample
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select (0 = left, 1 = right)
- i2s_sdata  out  1  serial data, MSB first
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- underrun  out  1  one-cycle pulse: frame loaded from empty FIFO

Behaviour:
- Reset: FIFO emptied, fifo_level=0, s_ready=1, i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, underrun=0, all counters 0, state IDLE.
- FIFO handshake:
  - Push when s_valid && s_ready.
  - s_ready = (fifo_level != FIFO_DEPTH), combinational from registered level.
  - Push and pop in the same cycle: level unchanged, both take effect.
  - Push while full is impossible (s_ready=0). Samples are never dropped.
- Clock divider:
  - div_cnt counts 0..BCLK_DIV-1; on wrap, i2s_bclk toggles.
  - BCLK period = 2*BCLK_DIV clk cycles.
  - All outputs are registered.
- Frame:
  - 64 BCLK periods: slot_bit 0..63. Left slot = bits 0..31, right slot = 32..63.
  - slot_bit advances on the clk cycle where i2s_bclk goes 1→0.
  - i2s_lrclk and i2s_sdata update on that same cycle.
  - i2s_lrclk = slot_bit[5].
- Data placement (I2S, one-bit delay):
  - Within each 32-bit slot, slot position 0 = 0.
  - Positions 1..WIDTH = sample MSB..LSB.
  - Positions WIDTH+1..31 = 0.
- Frame load:
  - On the falling-edge cycle that enters slot_bit 0, pop the FIFO head into a 2*WIDTH shift register.
  - If the FIFO is empty: load zeros and pulse underrun for one clk.
- FSM:
  - IDLE: bclk/lrclk/sdata held 0, counters held 0. enable=1 → RUN.
  - RUN: div_cnt starts at 0 with bclk=0. First falling edge (2*BCLK_DIV clk later) is slot_bit 0 of frame 0 and performs the first load.
  - If enable=0 in RUN: the current frame completes through slot_bit 63. On the next falling edge → IDLE with no load and no pop.
- Reset mid-frame: immediate return to reset values. Buffered samples are discarded.
- fifo_level is updated the cycle after push/pop.

Optional Feature:
- Macro I2S_LJ_FORMAT_EN selects left-justified format.
  - Defined:
    - i2s_lrclk = ~slot_bit[5] (1 = left).
    - Sample MSB sits at slot position 0, LSB at position WIDTH-1, positions WIDTH..31 = 0.
    - No one-bit delay.
  - Not defined: standard I2S as above.
- FIFO, handshake and timing are identical in both cases.

Test Plan:
- BCLK_DIV=2, FIFO_DEPTH=4. Push one pair (L=24'h800001, R=24'h7FFFFF), then raise enable → i2s_bclk period 4 clk, frame length 256 clk.
  - Left slot captured on BCLK rising edges: 0, 1,0…0,1, then 7 zeros.
  - Right slot: 0, 0, 23 ones, 7 zeros.
  - Exactly one pop; underrun never pulses in frame 0.
- Push 5 pairs back-to-back with enable=0 → s_ready drops after the 4th push, fifo_level=4, 5th pair held until a frame load frees an entry.
- Enable with an empty FIFO → underrun pulses once per frame at each slot_bit 0, sdata constant 0, lrclk still toggles every 32 BCLKs.
- Drop enable at slot_bit 10 → frame runs to slot_bit 63, bus idles low, fifo_level decremented only once.
- Assert rst at slot_bit 40 with fifo_level=3 → next cycle all outputs 0, fifo_level=0, s_ready=1.
- Rebuild with I2S_LJ_FORMAT_EN, L=24'hC00000 → lrclk=1 in left slot, sdata 1,1 at slot positions 0,1, zeros thereafter.
